// File: rtl/rr_arbiter8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8_pkg
// Description : Shared constants, FSM state type and helpers for rr_arbiter8.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned PTR_W   = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index of the set bit in a one-hot vector (0 for an all-zero vector).
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | PTR_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Combinational round-robin picker; returns the first set req
//               bit at or above ptr (wrapping 7->0) as a one-hot vector.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick
);

    always_comb begin
        logic             w_found;
        logic [PTR_W-1:0] w_idx;
        pick    = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // 3-bit index arithmetic provides the 7->0 wrap for free.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ptr + PTR_W'(k);
            if (!w_found && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-way round-robin arbiter with registered one-hot grant,
//               done/req-drop release and MAX_HOLD forced release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic               timeout
);

    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_idx;
    logic [7:0]         r_hold_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_grant_valid;
    logic               r_timeout;

    logic [NUM_REQ-1:0] w_pick;
    logic               w_owner_req;
    logic               w_hold_limit;
    logic               w_release;

    rr_pick8 u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick)
    );

    assign w_owner_req  = |(req & r_grant);
    assign w_hold_limit = (r_hold_cnt == c_HOLD_LAST);
    assign w_release    = done | ~w_owner_req | w_hold_limit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_idx         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant       <= w_pick;
                        r_grant_valid <= 1'b1;
                        r_idx         <= onehot_to_idx(w_pick);
                        r_hold_cnt    <= '0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        // Only a pure hold-limit release is reported as a timeout.
                        r_timeout     <= w_hold_limit & ~done & w_owner_req;
                        r_ptr         <= r_idx + PTR_W'(1);
                        r_state       <= IDLE;
                    end else if (!w_hold_limit) begin
                        r_hold_cnt    <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Directed vector table plus randomized run against a
//               round-robin reference model for rr_arbiter8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    localparam int unsigned MH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how long, and who is next.
    bit m_busy    = 1'b0;
    int m_owner   = 0;
    int m_ptr     = 0;
    int m_age     = 0;
    bit m_timeout = 1'b0;

    task automatic model_edge(input logic rn, input logic [7:0] rq, input logic dn);
        if (!rn) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_timeout = 0;
        end else if (!m_busy) begin
            m_timeout = 0;
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && rq[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_busy  = 1;
                    m_age   = 0;
                end
            end
        end else begin
            m_timeout = 0;
            if (dn || !rq[m_owner] || m_age == MH - 1) begin
                m_timeout = !dn && rq[m_owner] && (m_age == MH - 1);
                m_busy    = 0;
                m_ptr     = (m_owner + 1) % 8;
            end else begin
                m_age = m_age + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_invariants();
        check("onehot", 8'($countones(grant) <= 1), 8'd1);
        check("valid_consistent", {7'd0, grant_valid}, {7'd0, grant != 8'd0});
        check("timeout_vs_valid", {7'd0, timeout & grant_valid}, 8'd0);
    endtask

    task automatic step(input logic rn, input logic [7:0] rq, input logic dn);
        rst_n = rn; req = rq; done = dn;
        @(posedge clk);
        model_edge(rn, rq, dn);
        #1;
    endtask

    typedef struct {
        logic       rn;
        logic [7:0] rq;
        logic       dn;
        logic [7:0] eg;
        logic       et;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rn, input logic [7:0] rq, input logic dn,
                       input logic [7:0] eg, input logic et);
        vec_t v;
        v.rn = rn; v.rq = rq; v.dn = dn; v.eg = eg; v.et = et;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] r_req;
        logic [7:0] onehot;
        rst_n = 1'b0; req = 8'h00; done = 1'b0;

        // Reset, then 0x81 served 0 then 7; done in IDLE is ignored.
        add(0, 8'h00, 0, 8'h00, 0);
        add(1, 8'h81, 0, 8'h01, 0);
        add(1, 8'h81, 1, 8'h00, 0);
        add(1, 8'h81, 0, 8'h80, 0);
        add(1, 8'h81, 1, 8'h00, 0);
        add(1, 8'h00, 1, 8'h00, 0);
        // All requesting with done every cycle: fair rotation with idle gaps.
        for (int i = 0; i < 8; i++) begin
            onehot = 8'h01 << i;
            add(1, 8'hFF, 1, onehot, 0);
            add(1, 8'hFF, 1, 8'h00, 0);
        end
        add(1, 8'hFF, 1, 8'h01, 0);
        add(1, 8'hFF, 1, 8'h00, 0);
        // Hold limit of 4 cycles then a one-cycle timeout and regrant.
        for (int i = 0; i < 4; i++) add(1, 8'h10, 0, 8'h10, 0);
        add(1, 8'h10, 0, 8'h00, 1);
        add(1, 8'h10, 0, 8'h10, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        // Granted request drops while another is pending.
        add(1, 8'h04, 0, 8'h04, 0);
        add(1, 8'h08, 0, 8'h00, 0);
        add(1, 8'h08, 0, 8'h08, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        // Reset during BUSY overrides done; req[0] is favoured afterwards.
        add(1, 8'h20, 0, 8'h20, 0);
        add(0, 8'h20, 1, 8'h00, 0);
        add(1, 8'h21, 0, 8'h01, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        // done on the hold-limit cycle suppresses timeout.
        for (int i = 0; i < 4; i++) add(1, 8'h10, 0, 8'h10, 0);
        add(1, 8'h10, 1, 8'h00, 0);
        add(1, 8'h00, 0, 8'h00, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rn, tbl[i].rq, tbl[i].dn);
            check($sformatf("vec%0d_grant", i), grant, tbl[i].eg);
            check($sformatf("vec%0d_valid", i), {7'd0, grant_valid}, {7'd0, tbl[i].eg != 8'd0});
            check($sformatf("vec%0d_timeout", i), {7'd0, timeout}, {7'd0, tbl[i].et});
            check_invariants();
        end

        // Randomized run against the model; requests change only occasionally.
        step(0, 8'h00, 0);
        r_req = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) r_req = 8'($urandom);
            step(($urandom_range(199) != 0), r_req, ($urandom_range(5) == 0));
            check("rand_grant", grant, m_busy ? (8'h01 << m_owner) : 8'h00);
            check("rand_valid", {7'd0, grant_valid}, {7'd0, m_busy});
            check("rand_timeout", {7'd0, timeout}, {7'd0, m_timeout});
            check_invariants();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
